vga_timing_monitor: RTL and testbench



---
 rtl/vga_timing_monitor.sv | 167 ++++++++++++++++
 tb/tb_vga_timing_monitor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_monitor.sv
// Passive checker for VGA generator timing: measures line/frame geometry on ce_pix samples,
// compares against expected values and reports lock, sticky errors and a per-frame strobe.
module vga_timing_monitor #(
  parameter int unsigned EXP_HACTIVE = 640,
  parameter int unsigned EXP_HTOTAL  = 800,
  parameter int unsigned EXP_HSYNC   = 96,
  parameter int unsigned EXP_VACTIVE = 480,
  parameter int unsigned EXP_VTOTAL  = 525,
  parameter int unsigned EXP_VSYNC   = 2,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_pix,
  input  logic        HBlank,
  input  logic        HSync,
  input  logic        VBlank,
  input  logic        VSync,
  input  logic        clr_err,
  output logic [11:0] meas_hactive,
  output logic [11:0] meas_htotal,
  output logic [11:0] meas_hsync,
  output logic [11:0] meas_vactive,
  output logic [11:0] meas_vtotal,
  output logic [11:0] meas_vsync,
  output logic        frame_done,
  output logic        locked,
  output logic [6:0]  err
);

  localparam int unsigned CW = 12;
  localparam int unsigned GW = 4;
  localparam logic [CW-1:0] CMAX   = '1;
  localparam logic [CW-1:0] E_HACT = CW'(EXP_HACTIVE);
  localparam logic [CW-1:0] E_HTOT = CW'(EXP_HTOTAL);
  localparam logic [CW-1:0] E_HSY  = CW'(EXP_HSYNC);
  localparam logic [CW-1:0] E_VACT = CW'(EXP_VACTIVE);
  localparam logic [CW-1:0] E_VTOT = CW'(EXP_VTOTAL);
  localparam logic [CW-1:0] E_VSY  = CW'(EXP_VSYNC);
  localparam logic [GW-1:0] LOCK_N = GW'(LOCK_FRAMES);

  logic          hb_q, vb_q;
  logic          h_armed, v_armed;
  logic          h_bad, to_frame;
  logic [CW-1:0] hcnt, hact, hsy;
  logic [CW-1:0] vtot, vact, vsy;
  logic [GW-1:0] good_cnt;

  logic          ls, fs, h_chk, v_chk, to_hit, frame_good;
  logic [2:0]    h_mis, v_mis;
  logic [6:0]    err_set;
  logic [GW-1:0] good_inc;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] a, input logic inc);
    return (inc && (a != CMAX)) ? a + CW'(1) : a;
  endfunction

  // Event detection, comparisons and frame verdict for the current sample
  always_comb begin
    ls         = ce_pix & ~HBlank & hb_q;
    fs         = ce_pix & ~VBlank & vb_q;
    h_chk      = ls & h_armed;
    v_chk      = fs & v_armed;
    h_mis      = {hsy != E_HSY, hcnt != E_HTOT, hact != E_HACT};
    v_mis      = {vsy != E_VSY, vtot != E_VTOT, vact != E_VACT};
    // hcnt is about to reach (or sits at) saturation: the line never ended
    to_hit     = ce_pix & ~ls & (hcnt >= (CMAX - CW'(1)));
    err_set    = {to_hit, (v_chk ? v_mis : 3'b000), (h_chk ? h_mis : 3'b000)};
    frame_good = (v_mis == 3'b000) & ~h_bad & ~(h_chk & (|h_mis)) & ~to_frame & ~to_hit;
    good_inc   = (good_cnt >= LOCK_N) ? LOCK_N : good_cnt + GW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hb_q         <= 1'b0;
      vb_q         <= 1'b0;
      h_armed      <= 1'b0;
      v_armed      <= 1'b0;
      h_bad        <= 1'b0;
      to_frame     <= 1'b0;
      hcnt         <= '0;
      hact         <= '0;
      hsy          <= '0;
      vtot         <= '0;
      vact         <= '0;
      vsy          <= '0;
      good_cnt     <= '0;
      meas_hactive <= '0;
      meas_htotal  <= '0;
      meas_hsync   <= '0;
      meas_vactive <= '0;
      meas_vtotal  <= '0;
      meas_vsync   <= '0;
      frame_done   <= 1'b0;
      locked       <= 1'b0;
      err          <= '0;
    end else begin
      frame_done <= 1'b0;
      err        <= (clr_err ? 7'd0 : err) | err_set;
      if (ce_pix) begin
        hb_q <= HBlank;
        vb_q <= VBlank;

        // Horizontal counters
        if (ls) begin
          h_armed <= 1'b1;
          if (h_armed) begin
            meas_hactive <= hact;
            meas_htotal  <= hcnt;
            meas_hsync   <= hsy;
          end
          hcnt <= CW'(1);
          hact <= CW'(1);
          hsy  <= CW'(HSync);
        end else begin
          hcnt <= sat_inc(hcnt, 1'b1);
          hact <= sat_inc(hact, ~HBlank);
          hsy  <= sat_inc(hsy, HSync);
        end

        // Vertical counters; a line starting with the frame belongs to the new frame
        if (fs) begin
          v_armed <= 1'b1;
          if (v_armed) begin
            meas_vactive <= vact;
            meas_vtotal  <= vtot;
            meas_vsync   <= vsy;
            frame_done   <= 1'b1;
          end
          vtot <= CW'(ls);
          vact <= CW'(ls);
          vsy  <= CW'(ls & VSync);
        end else if (ls) begin
          vtot <= sat_inc(vtot, 1'b1);
          vact <= sat_inc(vact, ~VBlank);
          vsy  <= sat_inc(vsy, VSync);
        end

        if (fs)
          h_bad <= 1'b0;
        else if (h_chk && (|h_mis))
          h_bad <= 1'b1;

        if (fs)
          to_frame <= 1'b0;
        else if (to_hit)
          to_frame <= 1'b1;

        // Lock tracking
        if (v_chk) begin
          if (frame_good) begin
            good_cnt <= good_inc;
            locked   <= (good_inc == LOCK_N);
          end else begin
            good_cnt <= '0;
            locked   <= 1'b0;
          end
        end
        if (to_hit) begin
          good_cnt <= '0;
          locked   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Randomized-timing bench for vga_timing_monitor: a frame-level model predicts each
// frame_done result into a scoreboard that a negedge monitor pops and compares.
module tb_vga_timing_monitor;

  localparam int HA = 16, HT = 24, HS = 4, FP = 2;
  localparam int VA = 6, VT = 10, VS = 2, LK = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_pix = 1'b0;
  logic        hblank = 1'b0, hsync = 1'b0, vblank = 1'b0, vsync = 1'b0;
  logic        clr_err = 1'b0;
  logic [11:0] meas_hactive, meas_htotal, meas_hsync;
  logic [11:0] meas_vactive, meas_vtotal, meas_vsync;
  logic        frame_done, locked;
  logic [6:0]  err;

  vga_timing_monitor #(
    .EXP_HACTIVE(HA), .EXP_HTOTAL(HT), .EXP_HSYNC(HS),
    .EXP_VACTIVE(VA), .EXP_VTOTAL(VT), .EXP_VSYNC(VS), .LOCK_FRAMES(LK)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix),
    .HBlank(hblank), .HSync(hsync), .VBlank(vblank), .VSync(vsync),
    .clr_err(clr_err),
    .meas_hactive(meas_hactive), .meas_htotal(meas_htotal), .meas_hsync(meas_hsync),
    .meas_vactive(meas_vactive), .meas_vtotal(meas_vtotal), .meas_vsync(meas_vsync),
    .frame_done(frame_done), .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int va, vt, vs, ha, ht, hs, lk, er;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0;
  int   cyc_n = 0;
  int   fd_prev = 0, fd_last = 0;

  // model state
  int   err_m = 0, good_m = 0, lk_m = 0, idx_rst = 0, gap_mode = 0;
  bit   p_ok = 0, p_bad = 0;
  int   p_va, p_vt, p_vs, p_ha, p_ht, p_hs, p_all, p_last, p_vbits;
  bit   chk_badline = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (frame_done) begin
      fd_prev = fd_last;
      fd_last = cyc_n;
      if (sb.size() == 0) begin
        chk("sb_unexpected_frame_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("meas_vactive", int'(meas_vactive), e.va);
        chk("meas_vtotal",  int'(meas_vtotal),  e.vt);
        chk("meas_vsync",   int'(meas_vsync),   e.vs);
        chk("meas_hactive", int'(meas_hactive), e.ha);
        chk("meas_htotal",  int'(meas_htotal),  e.ht);
        chk("meas_hsync",   int'(meas_hsync),   e.hs);
        chk("locked",       int'(locked),       e.lk);
        chk("err",          int'(err),          e.er);
      end
    end
  end

  task automatic cyc(input bit ce, input bit hb, input bit hs, input bit vb, input bit vs, input bit clr);
    ce_pix = ce; hblank = hb; hsync = hs; vblank = vb; vsync = vs; clr_err = clr;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic pix(input bit hb, input bit hs, input bit vb, input bit vs, input bit clr);
    if (gap_mode == 2) begin
      int n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) idle();
    end
    cyc(1'b1, hb, hs, vb, vs, clr);
    if (gap_mode == 1) idle();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mha"}, int'(meas_hactive), 0);
    chk({tag, "_mht"}, int'(meas_htotal), 0);
    chk({tag, "_mhs"}, int'(meas_hsync), 0);
    chk({tag, "_mva"}, int'(meas_vactive), 0);
    chk({tag, "_mvt"}, int'(meas_vtotal), 0);
    chk({tag, "_mvs"}, int'(meas_vsync), 0);
    chk({tag, "_fd"},  int'(frame_done), 0);
    chk({tag, "_lk"},  int'(locked), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  function automatic int hbits(input int a, input int t, input int s);
    return ((a != HA) ? 1 : 0) | ((t != HT) ? 2 : 0) | ((s != HS) ? 4 : 0);
  endfunction

  // One frame: evaluate the previous frame at this frame's start, predict this one, drive it.
  task automatic gen_frame(input int nl, input int bad_y, input int b_ha, input int b_ht, input int b_hs,
                           input int stall_y, input bit clr_fs, input bit clr_mid, input int rst_y);
    int lha[16], lht[16], lhs[16];
    int ma[16], mt[16], ms[16];
    bit mvb[16], mvs[16];
    int nm, va, vs, all, last, vbits;
    for (int y = 0; y < nl; y++) begin
      lha[y] = HA; lht[y] = HT; lhs[y] = HS;
      if (y == bad_y)   begin lha[y] = b_ha; lht[y] = b_ht; lhs[y] = b_hs; end
      if (y == stall_y) begin lha[y] = 0;    lht[y] = 5000; lhs[y] = 0;    end
    end

    if (p_ok) begin
      exp_t e;
      if (clr_fs) err_m = p_last | p_vbits;
      else        err_m = err_m | p_all | p_vbits;
      if (p_bad) begin good_m = 0; lk_m = 0; end
      else begin good_m = (good_m < LK) ? good_m + 1 : LK; lk_m = (good_m == LK) ? 1 : 0; end
      e.va = p_va; e.vt = p_vt; e.vs = p_vs;
      e.ha = p_ha; e.ht = p_ht; e.hs = p_hs;
      e.lk = lk_m; e.er = err_m;
      sb.push_back(e);
    end

    // Lines as the checker sees them: an all-blank line merges into the one before it.
    nm = 0;
    for (int y = 0; y < nl; y++) begin
      if (lha[y] > 0) begin
        ma[nm] = lha[y]; mt[nm] = lht[y]; ms[nm] = lhs[y];
        mvb[nm] = (y >= VA); mvs[nm] = (y >= VA + 1) && (y < VA + 1 + VS);
        nm++;
      end else begin
        mt[nm-1] = (mt[nm-1] + lht[y] > 4095) ? 4095 : mt[nm-1] + lht[y];
        ms[nm-1] = ms[nm-1] + lhs[y];
      end
    end
    va = 0; vs = 0; all = 0;
    for (int i = 0; i < nm; i++) begin
      if (!mvb[i]) va++;
      if (mvs[i]) vs++;
      all |= hbits(ma[i], mt[i], ms[i]);
      if (mt[i] == 4095) all |= 64;
    end
    last  = hbits(ma[nm-1], mt[nm-1], ms[nm-1]);
    vbits = ((va != VA) ? 8 : 0) | ((nm != VT) ? 16 : 0) | ((vs != VS) ? 32 : 0);

    for (int y = 0; y < nl; y++) begin
      for (int x = 0; x < lht[y]; x++) begin
        bit hb, hsv, vb, vsv, clr;
        if (y == rst_y && x == 3) begin
          reset_n = 1'b0;
          cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          check_zero("midrst");
          reset_n = 1'b1;
          err_m = 0; good_m = 0; lk_m = 0; idx_rst = 0;
        end
        hb  = (x >= lha[y]);
        hsv = (x >= lha[y] + FP) && (x < lha[y] + FP + lhs[y]);
        vb  = (y >= VA);
        vsv = (y >= VA + 1) && (y < VA + 1 + VS);
        clr = (clr_fs && y == 0 && x == 0) || (clr_mid && y == 0 && x == 5);
        if (clr_mid && y == 0 && x == 5) err_m = 0;
        pix(hb, hsv, vb, vsv, clr);
        if (chk_badline && y == bad_y + 1 && x == 0) chk("badline_err2", int'(err[2]), 1);
      end
      if (y == stall_y) begin
        chk("timeout_err6", int'(err[6]), 1);
        chk("timeout_locked", int'(locked), 0);
        chk("timeout_meas_htotal_held", int'(meas_htotal), HT);
      end
    end

    p_ok = (idx_rst >= 1) && (rst_y < 0);
    p_va = va; p_vt = nm; p_vs = vs;
    p_ha = ma[nm-1]; p_ht = mt[nm-1]; p_hs = ms[nm-1];
    p_all = all; p_last = last; p_vbits = vbits;
    p_bad = (all != 0) || (vbits != 0);
    idx_rst++;
  endtask

  task automatic nominal();
    gen_frame(VT, -1, 0, 0, 0, -1, 1'b0, 1'b0, -1);
  endtask

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) idle();
    check_zero("reset");
    reset_n = 1'b1;

    // Continuous pixel enable
    gap_mode = 0;
    for (int f = 0; f < 4; f++) nominal();

    // Pixel enable every other clock
    gap_mode = 1;
    for (int f = 0; f < 3; f++) nominal();
    chk("frame_done_spacing", fd_last - fd_prev, 2 * HT * VT);

    // Random enable gaps with directed disturbances
    gap_mode = 2;
    gen_frame(VT - 1, -1, 0, 0, 0, -1, 1'b0, 1'b0, -1);
    nominal();
    nominal();
    gen_frame(VT, -1, 0, 0, 0, -1, 1'b0, 1'b1, -1);
    chk_badline = 1;
    gen_frame(VT, 4, HA, HT, HS - 1, -1, 1'b0, 1'b0, -1);
    chk_badline = 0;
    gen_frame(VT - 1, -1, 0, 0, 0, -1, 1'b0, 1'b0, -1);
    gen_frame(VT, -1, 0, 0, 0, -1, 1'b1, 1'b0, -1);
    nominal();
    gen_frame(VT, -1, 0, 0, 0, 4, 1'b0, 1'b0, -1);
    nominal();
    nominal();
    gen_frame(VT, -1, 0, 0, 0, -1, 1'b0, 1'b0, 3);
    for (int f = 0; f < 3; f++) nominal();

    for (int f = 0; f < 8; f++) begin
      int r  = $urandom_range(0, 3);
      int nl = (r >= 2) ? $urandom_range(9, 12) : VT;
      if (r == 1 || r == 3)
        gen_frame(nl, $urandom_range(1, 7), $urandom_range(14, 17), $urandom_range(24, 26),
                  $urandom_range(3, 5), -1, 1'b0, 1'b0, -1);
      else
        gen_frame(nl, -1, 0, 0, 0, -1, 1'b0, 1'b0, -1);
    end
    nominal();

    for (int i = 0; i < 20; i++) idle();
    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
